// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch controller with PC, prefetch FIFO and redirect flush
//
// Owns the PC, drives the instruction-memory address combinationally from it,
// and buffers {pc, instruction} pairs in a small prefetch FIFO. Decode takes
// the FIFO head through a valid/ready handshake. Execute redirects flush the
// FIFO and reload the PC.
//
// Optional feature macro: FETCH_WRAP_HALT_EN
//   defined   - fetching the last address stops fetch (HALT, halted=1) until a redirect
//   undefined - the PC wraps silently and halted is tied 0
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous reset, active low
//   start          in   1-cycle pulse, begin fetching from PC 0 (IDLE only)
//   imem_addr      out  instruction-memory address (equals pc)
//   imem_instr     in   instruction-memory read data (combinational)
//   redirect_valid in   branch/jump taken this cycle
//   redirect_pc    in   redirect target
//   if_valid       out  FIFO head holds a valid instruction
//   if_ready       in   decode accepts the head this cycle
//   if_instr       out  head instruction
//   if_pc          out  head PC
//   halted         out  fetch stopped on wrap

module fetch_sequencer #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              halted
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

`ifdef FETCH_WRAP_HALT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1} state_t;
`endif

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] slot_pc    [FIFO_DEPTH];
    logic [DATA_W-1:0] slot_instr [FIFO_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic pop;
    logic push;
    logic flush;
    logic pc_last;

    assign pop     = if_valid & if_ready;
    assign pc_last = (pc == {ADDR_W{1'b1}});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
`ifdef FETCH_WRAP_HALT_EN
                // The push of the last address is the final fetch before halting.
                if (push && pc_last) begin
                    state_next = S_HALT;
                end
`endif
            end
`ifdef FETCH_WRAP_HALT_EN
            S_HALT: begin
                if (redirect_valid) begin
                    state_next = S_RUN;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // Output/control decode: redirect wins over push, and a full FIFO can
    // still accept a push when decode pops in the same cycle.
    always_comb begin
        push  = 1'b0;
        flush = 1'b0;
        case (state)
            S_RUN: begin
                flush = redirect_valid;
                push  = !redirect_valid && ((count != FULL_CNT) || pop);
            end
`ifdef FETCH_WRAP_HALT_EN
            S_HALT: begin
                flush = redirect_valid;
            end
`endif
            default: begin
                push  = 1'b0;
                flush = 1'b0;
            end
        endcase
    end

    // PC: wraps naturally through ADDR_W-bit arithmetic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if ((state == S_IDLE) && start) begin
            pc <= '0;
        end else if (flush) begin
            pc <= redirect_pc;
        end else if (push) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    // Prefetch FIFO. A flush resets the pointers; any pop in the same cycle
    // has already been taken by decode, so nothing else is needed for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                slot_pc[i]    <= '0;
                slot_instr[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                slot_pc[tail]    <= pc;
                slot_instr[tail] <= imem_instr;
                tail             <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign imem_addr = pc;
    assign if_valid  = (count != '0);
    assign if_instr  = slot_instr[head];
    assign if_pc     = slot_pc[head];

`ifdef FETCH_WRAP_HALT_EN
    assign halted = (state == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer

module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [4:0]  redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [4:0]  if_pc;
    logic        halted;

    int tests;
    int fails;

    fetch_sequencer #(
        .ADDR_W    (5),
        .DATA_W    (32),
        .FIFO_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [4:0] a);
        return 32'hC0DE_0000 + 32'(a);
    endfunction

    // Instruction memory: word a holds C0DE00aa.
    assign imem_instr = instr_of(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic head(input string tag, input logic [4:0] p);
        chk({tag, " valid"}, 32'(if_valid), 32'd1);
        chk({tag, " pc"},    32'(if_pc),    32'(p));
        chk({tag, " instr"}, if_instr,      instr_of(p));
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        rst_n          = 1'b0;
        start          = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state
        tick();
        tick();
        chk("rst if_valid",  32'(if_valid),  32'd0);
        chk("rst if_instr",  if_instr,       32'd0);
        chk("rst if_pc",     32'(if_pc),     32'd0);
        chk("rst imem_addr", 32'(imem_addr), 32'd0);
        chk("rst halted",    32'(halted),    32'd0);
        rst_n = 1'b1;

        // Redirect ignored in IDLE
        redirect_valid = 1'b1;
        redirect_pc    = 5'd7;
        tick();
        redirect_valid = 1'b0;
        chk("idle redir addr",  32'(imem_addr), 32'd0);
        chk("idle redir valid", 32'(if_valid),  32'd0);
        tick();
        chk("idle redir valid2", 32'(if_valid), 32'd0);

        // 1: start, then A,B,C,D back to back
        if_ready = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("t1 valid after start", 32'(if_valid),  32'd0);
        chk("t1 addr after start",  32'(imem_addr), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            head("t1 head", 5'(k));
            chk("t1 addr", 32'(imem_addr), 32'(k + 1));
        end

        // 2: backpressure holds A with two entries buffered
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        if_ready = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        head("t2 first", 5'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            head("t2 hold", 5'd0);
            chk("t2 addr hold", 32'(imem_addr), 32'd2);
        end
        if_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            head("t2 release", 5'(k));
        end
        chk("t2 addr after release", 32'(imem_addr), 32'd5);

        // 3: redirect with two entries buffered
        if_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 5'd20;
        tick();
        redirect_valid = 1'b0;
        chk("t3 flushed valid", 32'(if_valid),  32'd0);
        chk("t3 addr",          32'(imem_addr), 32'd20);
        tick();
        head("t3 target", 5'd20);
        tick();
        head("t3 target held", 5'd20);
        chk("t3 addr held", 32'(imem_addr), 32'd22);

        // 4: redirect in the same cycle as the pop of PC 4
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        if_ready = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            head("t4 stream", 5'(k));
        end
        redirect_valid = 1'b1;
        redirect_pc    = 5'd20;
        tick();
        redirect_valid = 1'b0;
        chk("t4 no dup valid", 32'(if_valid),  32'd0);
        chk("t4 addr",         32'(imem_addr), 32'd20);
        tick();
        head("t4 target", 5'd20);
        tick();
        head("t4 next", 5'd21);

        // 5: asynchronous reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5 async valid", 32'(if_valid),  32'd0);
        chk("t5 async addr",  32'(imem_addr), 32'd0);
        chk("t5 async pc",    32'(if_pc),     32'd0);
        chk("t5 async instr", if_instr,       32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5 idle valid", 32'(if_valid),  32'd0);
            chk("t5 idle addr",  32'(imem_addr), 32'd0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        head("t5 restart", 5'd0);

        // 6: wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 5'd30;
        tick();
        redirect_valid = 1'b0;
        tick();
        head("t6 pc30", 5'd30);
        chk("t6 halted early", 32'(halted), 32'd0);
        tick();
        head("t6 pc31", 5'd31);
`ifdef FETCH_WRAP_HALT_EN
        chk("t6 halted", 32'(halted),    32'd1);
        chk("t6 addr",   32'(imem_addr), 32'd0);
        tick();
        chk("t6 drained", 32'(if_valid), 32'd0);
        tick();
        chk("t6 still drained", 32'(if_valid),  32'd0);
        chk("t6 still halted",  32'(halted),    32'd1);
        chk("t6 addr held",     32'(imem_addr), 32'd0);
`else
        chk("t6 halted", 32'(halted),    32'd0);
        chk("t6 addr",   32'(imem_addr), 32'd0);
        tick();
        head("t6 wrap pc0", 5'd0);
        tick();
        head("t6 wrap pc1", 5'd1);
        chk("t6 halted after wrap", 32'(halted),    32'd0);
        chk("t6 addr after wrap",   32'(imem_addr), 32'd2);
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 5'd0;
        tick();
        redirect_valid = 1'b0;
        chk("t6 resume halted", 32'(halted),   32'd0);
        chk("t6 resume valid",  32'(if_valid), 32'd0);
        tick();
        head("t6 resume", 5'd0);
        chk("t6 resume halted2", 32'(halted), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
